// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the writeback arbiter: result entries, source select
// and register address width.
package writeback_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int WB_DATA_W  = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0]  data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_ALU,
      WB_LSU_FIFO,
      WB_LSU_BYP
   } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry FIFO of writeback entries; head is visible combinationally
// and pointers wrap modulo DEPTH (DEPTH must be a power of two).
module wb_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      i_push,
   input  wb_entry_t i_data,
   input  logic      i_pop,
   output wb_entry_t o_head,
   output logic      o_full,
   output logic      o_empty
);

   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_head    = r_mem[r_rd_ptr];

   // Storage carries no reset; occupancy is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: merges ALU and buffered LSU results onto the single
// register-file write port and tracks pending LSU destinations.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int DATA_N     = WB_DATA_W,
   parameter int SIZE       = 32,
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [DATA_N-1:0]     alu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [REG_ADDR_W-1:0] lsu_rd,
   input  logic [DATA_N-1:0]     lsu_data,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic [REG_ADDR_W-1:0] q0_addr,
   input  logic [REG_ADDR_W-1:0] q1_addr,
   output logic                  q0_busy,
   output logic                  q1_busy,
   output logic                  stall_req,
   output logic                  wr_en,
   output logic [REG_ADDR_W-1:0] w_addr,
   output logic [DATA_N-1:0]     w_data
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   wb_entry_t             w_lsu_entry;
   wb_entry_t             w_head;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_lsu_acc;
   logic                  w_alu_win;
   logic                  w_push;
   logic                  w_pop;
   wb_src_e               w_src;
   logic [REG_ADDR_W-1:0] w_sel_rd;
   logic [DATA_N-1:0]     w_sel_data;
   logic [CNT_W-1:0]      w_starve_inc;
   logic [SIZE-1:0]       w_busy_nxt;
   logic [SIZE-1:0]       r_busy;
   logic [CNT_W-1:0]      r_starve;

   assign w_lsu_entry = '{rd: lsu_rd, data: lsu_data};
   assign lsu_ready   = !w_full;
   assign w_lsu_acc   = lsu_valid && !w_full;
   assign w_alu_win   = alu_valid && (alu_rd != '0);
   assign q0_busy     = r_busy[q0_addr];
   assign q1_busy     = r_busy[q1_addr];

   // Bypass is only legal with an empty FIFO, otherwise ordering breaks.
   always_comb begin
      w_src = WB_NONE;
      if (w_alu_win)                         w_src = WB_ALU;
      else if (!w_empty)                     w_src = WB_LSU_FIFO;
      else if (w_lsu_acc && lsu_rd != '0)    w_src = WB_LSU_BYP;
   end

   assign w_push = w_lsu_acc && (lsu_rd != '0) && (w_src != WB_LSU_BYP);
   assign w_pop  = (w_src == WB_LSU_FIFO);

   always_comb begin
      w_sel_rd   = lsu_rd;
      w_sel_data = lsu_data;
      case (w_src)
         WB_ALU: begin
            w_sel_rd   = alu_rd;
            w_sel_data = alu_data;
         end
         WB_LSU_FIFO: begin
            w_sel_rd   = w_head.rd;
            w_sel_data = w_head.data;
         end
         default: ;
      endcase
   end

   // A new issue to the same register outranks the completing write.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_src == WB_LSU_FIFO || w_src == WB_LSU_BYP) w_busy_nxt[w_sel_rd] = 1'b0;
      if (issue_valid && issue_rd != '0)             w_busy_nxt[issue_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   assign w_starve_inc = r_starve + CNT_W'(1);

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_lsu_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en     <= 1'b0;
         w_addr    <= '0;
         w_data    <= '0;
         stall_req <= 1'b0;
         r_starve  <= '0;
         r_busy    <= '0;
      end else begin
         wr_en     <= (w_src != WB_NONE);
         r_busy    <= w_busy_nxt;
         stall_req <= 1'b0;
         if (w_src != WB_NONE) begin
            w_addr <= w_sel_rd;
            w_data <= w_sel_data;
         end
         if (w_empty || w_pop) begin
            r_starve <= '0;
         end else if (w_starve_inc == CNT_W'(STARVE_MAX)) begin
            r_starve  <= '0;
            stall_req <= 1'b1;
         end else begin
            r_starve <= w_starve_inc;
         end
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter with hand-computed
// expectations; inputs change 1ns after the rising edge and are sampled there.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  q0_addr = '0;
  logic [4:0]  q1_addr = '0;
  logic        q0_busy, q1_busy, stall_req, wr_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  int n_chk  = 0;
  int n_pass = 0;

  writeback_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .q0_addr(q0_addr), .q1_addr(q1_addr), .q0_busy(q0_busy), .q1_busy(q1_busy),
    .stall_req(stall_req), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && stall_req && alu_valid) $error("protocol: alu_valid during stall_req");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #2;
    check("rst_wr_en", wr_en, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_w_data", w_data, 0);
    check("rst_stall", stall_req, 0);
    check("rst_ready", lsu_ready, 1);
    q0_addr = 5'd7;
    #1;
    check("rst_busy7", q0_busy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // single ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 0;
    check("alu_wr_en", wr_en, 1);
    check("alu_w_addr", w_addr, 5);
    check("alu_w_data", w_data, 32'hDEADBEEF);
    check("alu_ready", lsu_ready, 1);
    tick();
    check("alu_idle", wr_en, 0);

    // issue rd7, LSU bypass completes it three cycles later
    issue_valid = 1; issue_rd = 7;
    tick();
    issue_valid = 0;
    check("busy7_set", q0_busy, 1);
    tick();
    tick();
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234;
    check("busy7_pre", q0_busy, 1);
    check("byp_ready", lsu_ready, 1);
    tick();
    lsu_valid = 0;
    check("byp_wr_en", wr_en, 1);
    check("byp_w_addr", w_addr, 7);
    check("byp_w_data", w_data, 32'h1234);
    check("busy7_clr", q0_busy, 0);

    // ALU every cycle while LSU fills the FIFO; stall after 8 blocked cycles
    for (int c = 0; c < 9; c++) begin
      alu_valid = 1; alu_rd = 5'(c + 1); alu_data = 32'h100 + c;
      lsu_valid = 1;
      lsu_rd    = 5'(10 + ((c < 4) ? c : 4));
      lsu_data  = 32'hA0 + ((c < 4) ? c : 4);
      tick();
      check($sformatf("starve_addr%0d", c), w_addr, 32'(c + 1));
      check($sformatf("starve_ready%0d", c), lsu_ready, (c < 3) ? 1 : 0);
      check($sformatf("starve_stall%0d", c), stall_req, (c == 8) ? 1 : 0);
    end
    alu_valid = 0;
    #1;
    check("full_no_push", lsu_ready, 0);
    tick();
    check("stall_pop_en", wr_en, 1);
    check("stall_pop_addr", w_addr, 10);
    check("stall_pop_data", w_data, 32'hA0);
    check("stall_cleared", stall_req, 0);
    check("ready_back", lsu_ready, 1);
    // pop and push together at count 3
    tick();
    lsu_valid = 0;
    check("pp_addr", w_addr, 11);
    check("pp_data", w_data, 32'hA1);
    check("pp_ready", lsu_ready, 1);
    for (int k = 2; k < 5; k++) begin
      tick();
      check($sformatf("drain_en%0d", k), wr_en, 1);
      check($sformatf("drain_addr%0d", k), w_addr, 32'(10 + k));
      check($sformatf("drain_data%0d", k), w_data, 32'hA0 + k);
    end
    tick();
    check("drain_done", wr_en, 0);

    // same-edge set and clear of rd9: set wins
    q1_addr = 9;
    issue_valid = 1; issue_rd = 9;
    tick();
    check("busy9_set", q1_busy, 1);
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
    tick();
    issue_valid = 0;
    check("sc_wr_addr", w_addr, 9);
    check("sc_busy9", q1_busy, 1);
    tick();
    lsu_valid = 0;
    check("busy9_clr", q1_busy, 0);

    // rd0 results are dropped; the LSU beat is still accepted
    alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h66;
    #1;
    check("rd0_ready", lsu_ready, 1);
    tick();
    alu_valid = 0; lsu_valid = 0;
    check("rd0_no_wr", wr_en, 0);
    tick();
    check("rd0_no_enq", wr_en, 0);

    // reset mid-operation with 3 queued entries and busy bits set
    q0_addr = 20; q1_addr = 21;
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1; alu_rd = 5'(c + 2); alu_data = 32'h200 + c;
      lsu_valid = 1; lsu_rd = 5'(20 + c); lsu_data = 32'hB0 + c;
      issue_valid = (c < 2); issue_rd = 5'(20 + c);
      tick();
    end
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    check("pre_rst_busy20", q0_busy, 1);
    check("pre_rst_busy21", q1_busy, 1);
    check("pre_rst_wr_en", wr_en, 1);
    #2;
    rst_n = 0;
    #1;
    check("arst_wr_en", wr_en, 0);
    check("arst_busy20", q0_busy, 0);
    check("arst_busy21", q1_busy, 0);
    check("arst_ready", lsu_ready, 1);
    check("arst_w_addr", w_addr, 0);
    tick();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post_rst_no_wr%0d", c), wr_en, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
